// File: rtl/mult_pipe2_pkg.sv
// Shared constants and slice-width helper for the mult_pipe2 pipelined multiplier.
// Build option: MULT_PIPE2_IN_REG_EN adds an input register ahead of stage 1.
package mult_pipe2_pkg;

    localparam int SIZE_DEF = 16;
    localparam int LVL_DEF  = 2;

    // ceil(size/lvl); an illegal lvl falls back to one slice so elaboration reaches the range check
    function automatic int slice_w(input int size, input int lvl);
        if (lvl < 1) return size;
        return (size + lvl - 1) / lvl;
    endfunction

endpackage

// File: rtl/mult_pipe2_stage.sv
// One pipeline stage: adds a * (lowest remaining slice of b) << SHIFT to the carried sum,
// and forwards a and the unconsumed slices of b alongside the new sum.
module mult_pipe2_stage
    import mult_pipe2_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int SW    = 8,
    parameter int BW    = 16,
    parameter int SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SIZE-1:0]   a_i,
    input  logic [BW-1:0]     b_i,
    input  logic [2*SIZE-1:0] sum_i,
    output logic [SIZE-1:0]   a_o,
    output logic [BW-1:0]     b_o,
    output logic [2*SIZE-1:0] sum_o
);

    localparam int PW = 2 * SIZE;

    logic [PW-1:0]   pp;
    logic [PW-1:0]   sum_d, sum_q;
    logic [BW-1:0]   b_d, b_q;
    logic [SIZE-1:0] a_q;

    // Full product always fits in PW bits, so the shifted partial sum never needs truncating
    always_comb begin
        pp    = PW'(a_i) * PW'(b_i[SW-1:0]);
        sum_d = sum_i + (pp << SHIFT);
        b_d   = b_i >> SW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_d;
            sum_q <= sum_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign sum_o = sum_q;

endmodule

// File: rtl/mult_pipe2.sv
// LVL-stage unsigned SIZE x SIZE multiplier, b consumed LSB-first one slice per stage.
// Build option: MULT_PIPE2_IN_REG_EN registers a/b before stage 1 (latency LVL+1).
module mult_pipe2
    import mult_pipe2_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int LVL  = LVL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] pdt
);

    localparam int SW = slice_w(SIZE, LVL);
    localparam int BW = SW * LVL;

    generate
        if (LVL < 1 || LVL > SIZE || SIZE < 2) begin : g_bad_cfg
            $error("mult_pipe2: illegal configuration, need SIZE>=2 and 1<=LVL<=SIZE");
        end
    endgenerate

    logic [SIZE-1:0]   a_pipe [0:LVL];
    logic [BW-1:0]     b_pipe [0:LVL];
    logic [2*SIZE-1:0] s_pipe [0:LVL];

`ifdef MULT_PIPE2_IN_REG_EN
    logic [SIZE-1:0] a_in_q, b_in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_in_q <= '0;
            b_in_q <= '0;
        end else begin
            a_in_q <= a;
            b_in_q <= b;
        end
    end

    assign a_pipe[0] = a_in_q;
    assign b_pipe[0] = BW'(b_in_q);
`else
    assign a_pipe[0] = a;
    assign b_pipe[0] = BW'(b);
`endif
    assign s_pipe[0] = '0;

    // b is zero-padded to LVL*SW bits so a short or empty last slice needs no special case
    generate
        for (genvar i = 0; i < LVL; i++) begin : g_stage
            mult_pipe2_stage #(
                .SIZE (SIZE),
                .SW   (SW),
                .BW   (BW),
                .SHIFT(i * SW)
            ) u_stage (
                .clk  (clk),
                .rst_n(rst_n),
                .a_i  (a_pipe[i]),
                .b_i  (b_pipe[i]),
                .sum_i(s_pipe[i]),
                .a_o  (a_pipe[i+1]),
                .b_o  (b_pipe[i+1]),
                .sum_o(s_pipe[i+1])
            );
        end
    endgenerate

    assign pdt = s_pipe[LVL];

    // Last stage's forwarded operands have no consumer; they are trimmed in synthesis
    logic unused_tail;
    assign unused_tail = ^{a_pipe[LVL], b_pipe[LVL]};

endmodule

// File: tb/tb_mult_pipe2.sv
// Bench for mult_pipe2: four instances (LVL 1,2,4,16, SIZE 16) share stimulus; latency
// adds one when MULT_PIPE2_IN_REG_EN is defined.
module tb_mult_pipe2;

`ifdef MULT_PIPE2_IN_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int ND = 4;

    function automatic int lvl_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int lat(input int g);
        return lvl_of(g) + EXTRA;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [31:0] pdt [ND];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            mult_pipe2 #(.SIZE(16), .LVL(lvl_of(g))) u_dut (
                .clk  (clk),
                .rst_n(rst_n),
                .a    (a),
                .b    (b),
                .pdt  (pdt[g])
            );
        end
    endgenerate

    // Scoreboard: product of each sampled pair travels down a plain delay line
    logic [31:0] exp_q [ND][17];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++)
                for (int j = 0; j < 17; j++) exp_q[d][j] <= '0;
        end else begin
            for (int d = 0; d < ND; d++) begin
                exp_q[d][0] <= 32'(a) * 32'(b);
                for (int j = 1; j < 17; j++) exp_q[d][j] <= exp_q[d][j-1];
            end
        end
    end

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s lvl=%0d observed=%h expected=%h", tag, lvl_of(d), obs, expv);
        end
    endtask

    // One-cycle operand pulse followed by zeros; each instance shows pv only at its own latency
    task automatic pulse(input string tag, input logic [15:0] va, input logic [15:0] vb, input logic [31:0] pv);
        a = va;
        b = vb;
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            a = '0;
            b = '0;
            for (int d = 0; d < ND; d++)
                check(tag, d, pdt[d], (k == lat(d) - 1) ? pv : 32'h0);
        end
    endtask

    initial begin
        // Reset held 3 cycles with live operands
        #1 rst_n = 1'b0;
        a = 16'h1234;
        b = 16'h5678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) check("reset_hold", d, pdt[d], 32'h0);
        end
        rst_n = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++)
                check("reset_release", d, pdt[d], (k >= lat(d) - 1) ? 32'h06260060 : 32'h0);
        end

        // Flush the held operands
        a = '0;
        b = '0;
        repeat (18) @(negedge clk);
        for (int d = 0; d < ND; d++) check("flush", d, pdt[d], 32'h0);

        pulse("lat_3x5",      16'h0003, 16'h0005, 32'h0000000F);
        pulse("max_x_max",    16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        pulse("max_x_zero",   16'hFFFF, 16'h0000, 32'h00000000);
        pulse("zero_x_max",   16'h0000, 16'hFFFF, 32'h00000000);
        pulse("one_x_msb",    16'h0001, 16'h8000, 32'h00008000);
        pulse("mixed",        16'h00FF, 16'h0101, 32'h0000FFFF);

        // Back-to-back random stream with a half-cycle reset pulse in the middle
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) check("stream", d, pdt[d], exp_q[d][lat(d)-1]);
            if (c == 7) begin
                #1 rst_n = 1'b0;
                #1;
                for (int d = 0; d < ND; d++) check("midreset_zero", d, pdt[d], 32'h0);
                #2 rst_n = 1'b1;
            end
            a = 16'($urandom);
            b = 16'($urandom);
        end
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            a = '0;
            b = '0;
            for (int d = 0; d < ND; d++) check("drain", d, pdt[d], exp_q[d][lat(d)-1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_pipe2.md
MULT_PIPE2 -- requirements
Module: mult_pipe2

Interface
REQ-001 Parameter SIZE, default 16: operand width in bits; legal range 2..64.
REQ-002 Parameter LVL, default 2: number of pipeline register stages between the operands and pdt; legal range 1..SIZE.
REQ-003 clk  input  1  single clock; all registers update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 a  input  SIZE  unsigned multiplicand.
REQ-006 b  input  SIZE  unsigned multiplier.
REQ-007 pdt  output  2*SIZE  unsigned product, driven directly from a register.

Function
REQ-008 pdt SHALL equal a*b, unsigned, full 2*SIZE-bit precision; no truncation, rounding or saturation.
REQ-009 The first stage SHALL sample a and b on each rising edge.
REQ-010 The product of operands sampled at rising edge n SHALL appear on pdt immediately after rising edge n+LVL-1 (latency LVL cycles, throughput one product per cycle).
REQ-011 b SHALL be split LSB-first into LVL slices of ceil(SIZE/LVL) bits; the last slice takes the remainder.
REQ-012 Stage i SHALL add the shifted partial product a*slice_i to the running sum carried from stage i-1.
REQ-013 Each stage SHALL forward a and the unconsumed slices of b with its running sum, so in-flight operations never interfere.
REQ-014 No pipeline bubbles, stalls or enables: every stage advances every cycle.
REQ-015 Boundary: a=0 or b=0 SHALL give pdt=0; a=b=2^SIZE-1 SHALL give (2^SIZE-1)^2 with no overflow.
REQ-016 LVL=1 SHALL degenerate to a single registered full multiply.
REQ-017 X or Z on an input SHALL affect only the product of the cycle that sampled it.

Reset
REQ-018 rst_n low SHALL asynchronously clear every pipeline register; pdt SHALL read 0 while rst_n is low.
REQ-019 After rst_n deasserts, pdt SHALL stay 0 until the first product sampled after release reaches the output.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight products; none SHALL reappear after release.
REQ-021 Release of rst_n is synchronised by the parent; the block adds no reset synchroniser.

Configuration
REQ-022 Macro MULT_PIPE2_IN_REG_EN defined: an extra input register SHALL capture a and b before stage 1, making the latency LVL+1 cycles.
REQ-023 Macro MULT_PIPE2_IN_REG_EN undefined: stage 1 SHALL take a and b directly, latency LVL cycles; products SHALL be identical in both builds.

Structure
REQ-024 Package mult_pipe2_pkg SHALL hold the default SIZE and LVL constants and a function computing slice width ceil(SIZE/LVL).
REQ-025 One stage sub-module, mult_pipe2_stage, SHALL implement partial product, accumulate and forwarding registers; the top SHALL instantiate it LVL times with a generate loop.
REQ-026 Elaboration SHALL fail with a message if LVL<1, LVL>SIZE or SIZE<2.

Verification
REQ-027 Reset: hold rst_n low for 3 cycles while driving a=16'h1234, b=16'h5678 -> pdt=0 throughout; 32'h06260060 appears LVL cycles after release.
REQ-028 Latency, SIZE=16, LVL=2: a=3, b=5 at edge n, then zeros -> pdt=15 after edge n+1 only, 0 afterwards.
REQ-029 Corners: a=b=16'hFFFF -> 32'hFFFE0001; a=16'hFFFF, b=0 -> 0; a=1, b=16'h8000 -> 32'h00008000.
REQ-030 Back-to-back: change a and b on every negedge for 15 cycles with random values -> each pdt equals the scoreboard product delayed by LVL cycles, with no gaps.
REQ-031 Mid-stream reset: pulse rst_n low for half a cycle during the random stream -> pdt=0 immediately and no pre-reset product is ever emitted.
REQ-032 Sweep: repeat REQ-030 for LVL in {1,2,4,16} and with MULT_PIPE2_IN_REG_EN defined -> latency LVL or LVL+1, results exact.
